push_debounce: RTL and testbench

Multi-channel push-button conditioner placed between the board push-buttons and the pixel generation stage of the VGA display path. Each channel synchronises a raw button input, debounces it with a qualification counter, and outputs a stable level plus single-cycle press and release strobes. Pixel generation consumes these strobes to move or animate the on-screen object exactly once per press, instead of once per bounce or per frame.

---
 rtl/push_debounce_pkg.sv | 40 ++++
 rtl/push_debounce_channel.sv | 154 +++++++++++++++
 rtl/push_debounce.sv | 54 +++++
 tb/tb_push_debounce.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/push_debounce_pkg.sv
// push_debounce_pkg
//   Shared definitions for the push-button conditioner:
//     - btn_state_e : per-channel debounce FSM state
//     - btn_evt_t   : per-channel registered outputs (level + strobes)
//     - DEF_*       : default timing constants for a 50 MHz clock
//     - cnt_width() : width of the qualification / repeat counters
package push_debounce_pkg;

  // 10 ms debounce, 500 ms first repeat, 100 ms repeat period at 50 MHz.
  localparam int DEF_N_BTN           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 500_000;
  localparam int DEF_REPEAT_DELAY    = 25_000_000;
  localparam int DEF_REPEAT_PERIOD   = 5_000_000;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

  // Per-channel response bundle. 'rel' rather than 'release' because the
  // latter is a reserved word.
  typedef struct packed {
    logic lvl;
    logic press;
    logic rel;
  } btn_evt_t;

  // Counters only ever count up to (limit-1) and are compared for equality,
  // so $clog2 of the largest limit plus one bit of headroom is always enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/push_debounce_channel.sv
// debounce_channel
//   One button channel: 2-flop synchroniser, 4-state debounce FSM with a
//   qualification counter, registered level and press/release strobes.
//   Optional auto-repeat of press strobes while held (BTN_AUTOREPEAT_EN).
//
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous active-high reset
//     noisy  in   raw asynchronous button level, 1 = pressed
//     evt    out  registered {lvl, press, rel}
//
//   Macro BTN_AUTOREPEAT_EN: when defined, IDLE_HIGH runs a repeat counter
//   that issues extra press strobes REPEAT_DELAY cycles after entry and then
//   every REPEAT_PERIOD cycles. When undefined no repeat logic exists.
module debounce_channel
  import push_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int CW              = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY,
                                            REPEAT_PERIOD)
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     noisy,
  output btn_evt_t evt
);

  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          s;
  btn_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          lvl_n, press_n, rel_n;
  logic          rep_fire;

  // sync_q[0] may go metastable; only sync_q[1] feeds any decision.
  assign s = sync_q[1];

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lvl_n   = evt.lvl;
    press_n = 1'b0;
    rel_n   = 1'b0;
    case (state)
      IDLE_LOW: begin
        if (s) begin
          state_n = WAIT_HIGH;
          cnt_n   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          // bounce: fall back, level untouched, qualification restarts
          state_n = IDLE_LOW;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
          lvl_n   = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_n = WAIT_LOW;
          cnt_n   = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_n = IDLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = IDLE_LOW;
          cnt_n   = '0;
          lvl_n   = 1'b0;
          rel_n   = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      state  <= IDLE_LOW;
      cnt    <= '0;
      evt    <= '0;
    end else begin
      sync_q    <= {sync_q[0], noisy};
      state     <= state_n;
      cnt       <= cnt_n;
      evt.lvl   <= lvl_n;
      // repeat strobes only fire while staying in IDLE_HIGH, so they can
      // never collide with a qualification or a release strobe
      evt.press <= press_n | rep_fire;
      evt.rel   <= rel_n;
    end
  end

  // --------------------------------------------------------- auto-repeat
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] rcnt, rcnt_n;
  logic          rep_armed, rep_armed_n;  // first delay elapsed

  // Counter only advances on cycles that stay in IDLE_HIGH; any entry into
  // IDLE_HIGH (from either WAIT state) therefore starts from zero with the
  // long initial delay, and leaving for WAIT_LOW clears it.
  always_comb begin
    rcnt_n      = '0;
    rep_armed_n = 1'b0;
    rep_fire    = 1'b0;
    if (state == IDLE_HIGH && s) begin
      rep_armed_n = rep_armed;
      if (rcnt == (rep_armed ? RP_LAST : RD_LAST)) begin
        rep_fire    = 1'b1;
        rcnt_n      = '0;
        rep_armed_n = 1'b1;
      end else begin
        rcnt_n = rcnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt      <= '0;
      rep_armed <= 1'b0;
    end else begin
      rcnt      <= rcnt_n;
      rep_armed <= rep_armed_n;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/push_debounce.sv
// push_debounce
//   N_BTN-channel push-button conditioner for the VGA pixel path. Each
//   channel is an independent debounce_channel instance; outputs are
//   registered inside the channels.
//
//   Ports:
//     clk            in   [1]      system clock
//     rst            in   [1]      synchronous active-high reset
//     noisy          in   [N_BTN]  raw button levels, 1 = pressed
//     clean          out  [N_BTN]  debounced levels
//     press_pulse    out  [N_BTN]  1-cycle strobe per accepted press
//                                  (plus auto-repeats when enabled)
//     release_pulse  out  [N_BTN]  1-cycle strobe per accepted release
//
//   Macro BTN_AUTOREPEAT_EN enables auto-repeat press strobes.
module push_debounce
  import push_debounce_pkg::*;
#(
  parameter int N_BTN           = DEF_N_BTN,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] noisy,
  output logic [N_BTN-1:0] clean,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

  btn_evt_t [N_BTN-1:0] evt;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .CW              (CW)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .noisy (noisy[i]),
      .evt   (evt[i])
    );

    assign clean[i]         = evt[i].lvl;
    assign press_pulse[i]   = evt[i].press;
    assign release_pulse[i] = evt[i].rel;
  end

endmodule

// File: tb/tb_push_debounce.sv
module tb_push_debounce;

  localparam int N  = 4;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 3;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit RPT = 1'b1;
`else
  localparam bit RPT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] noisy = '1;
  logic [N-1:0] clean, press_pulse, release_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  int press_cnt[N];
  int rel_cnt[N];

  push_debounce #(
    .N_BTN           (N),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .noisy         (noisy),
    .clean         (clean),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------------------- model
  // s is noisy delayed by two edges. A channel's level flips once the
  // synchronised input has disagreed with it on D+1 consecutive edges
  // (one edge to leave IDLE, D qualifying edges). Auto-repeat counts edges
  // spent continuously held in the accepted-high state.
  logic [N-1:0] m_s0 = '0, m_s1 = '0, m_clean = '0, m_press = '0, m_rel = '0;
  int m_run[N];
  int m_rep[N];

  initial begin
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0; m_rep[i] = 0; press_cnt[i] = 0; rel_cnt[i] = 0;
    end
  end

  always @(posedge clk) begin : model
    logic [N-1:0] c, p, r;
    int rn[N];
    int rp[N];
    logic s;
    if (rst) begin
      m_s0 <= '0; m_s1 <= '0; m_clean <= '0; m_press <= '0; m_rel <= '0;
      for (int i = 0; i < N; i++) begin
        m_run[i] <= 0; m_rep[i] <= 0;
      end
    end else begin
      c = m_clean; p = '0; r = '0; rn = m_run; rp = m_rep;
      for (int i = 0; i < N; i++) begin
        s = m_s1[i];
        if (s != c[i]) begin
          rn[i] = rn[i] + 1;
          rp[i] = 0;
          if (rn[i] == D + 1) begin
            c[i] = s; rn[i] = 0;
            if (s) p[i] = 1'b1; else r[i] = 1'b1;
          end
        end else begin
          if (c[i] && rn[i] == 0) begin
            rp[i] = rp[i] + 1;
            if (RPT && rp[i] >= RD && (rp[i] - RD) % RP == 0) p[i] = 1'b1;
          end else begin
            rp[i] = 0;
          end
          rn[i] = 0;
        end
      end
      m_clean <= c; m_press <= p; m_rel <= r;
      for (int i = 0; i < N; i++) begin
        m_run[i] <= rn[i]; m_rep[i] <= rp[i];
      end
      m_s1 <= m_s0;
      m_s0 <= noisy;
    end
  end

  // ----------------------------------------------------- compare + count
  always @(negedge clk) begin
    n_cmp++;
    if ({clean, press_pulse, release_pulse} !== {m_clean, m_press, m_rel}) begin
      n_bad++;
      $display("FAIL model_cmp t=%0t clean %b/%b press %b/%b release %b/%b (got/exp)",
               $time, clean, m_clean, press_pulse, m_press, release_pulse, m_rel);
    end
    for (int i = 0; i < N; i++) begin
      if (press_pulse[i] === 1'b1) press_cnt[i]++;
      if (release_pulse[i] === 1'b1) rel_cnt[i]++;
    end
  end

  // ------------------------------------------------------------ directed
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int pc, rc;
  logic [4:0] bounce;

  initial begin
    // reset with all buttons held
    noisy = 4'b1111; rst = 1'b1;
    tick(3);
    chk("rst_clean", clean, 4'b0000);
    chk("rst_press", press_pulse, 4'b0000);
    chk("rst_release", release_pulse, 4'b0000);
    rst = 1'b0;
    tick(6);
    chk("post_rst_edge6_clean", clean, 4'b0000);
    tick(1);
    chk("post_rst_edge7_clean", clean, 4'b1111);
    chk("post_rst_edge7_press", press_pulse, 4'b1111);
    tick(1);
    chk("post_rst_edge8_press", press_pulse, 4'b0000);
    noisy = 4'b0000;
    tick(6);
    chk("rel_all_edge6_clean", clean, 4'b1111);
    tick(1);
    chk("rel_all_edge7_clean", clean, 4'b0000);
    chk("rel_all_edge7_release", release_pulse, 4'b1111);
    tick(3);

    // clean press / release on channel 0
    noisy = 4'b0001;
    tick(7);
    chk("ch0_press_clean", clean, 4'b0001);
    chk("ch0_press_pulse", press_pulse, 4'b0001);
    tick(1);
    chk("ch0_press_one_cycle", press_pulse, 4'b0000);
    noisy = 4'b0000;
    tick(6);
    chk("ch0_rel_edge6_clean", clean, 4'b0001);
    tick(1);
    chk("ch0_rel_clean", clean, 4'b0000);
    chk("ch0_rel_pulse", release_pulse, 4'b0001);
    tick(3);

    // bounce on channel 1
    pc = press_cnt[1]; rc = rel_cnt[1];
    bounce = 5'b01101;  // applied LSB first: 1,0,1,1,0
    for (int k = 0; k < 5; k++) begin
      noisy[1] = bounce[k];
      tick(1);
    end
    noisy[1] = 1'b1;
    tick(6);
    chk("ch1_bounce_edge6_clean", clean, 4'b0000);
    tick(1);
    chk("ch1_bounce_press", press_pulse, 4'b0010);
    tick(3);
    chk_int("ch1_bounce_press_count", press_cnt[1] - pc, 1);
    chk_int("ch1_bounce_release_count", rel_cnt[1] - rc, 0);
    noisy = 4'b0000;
    tick(10);

    // independent channels 2 and 3
    noisy = 4'b1100;
    tick(7);
    chk("ch23_same_cycle_press", press_pulse, 4'b1100);
    chk("ch23_clean", clean, 4'b1100);
    noisy = 4'b0000;
    tick(7);
    chk("ch23_same_cycle_release", release_pulse, 4'b1100);
    tick(3);
    pc = press_cnt[3]; rc = rel_cnt[3];
    noisy = 4'b1100;
    tick(3);
    noisy = 4'b0100;
    tick(4);
    chk("ch3_abort_press", press_pulse, 4'b0100);
    tick(3);
    chk("ch3_abort_clean", clean, 4'b0100);
    chk_int("ch3_abort_press_count", press_cnt[3] - pc, 0);
    chk_int("ch3_abort_release_count", rel_cnt[3] - rc, 0);
    noisy = 4'b0000;
    tick(10);

    // long hold on channel 0 (auto-repeat when compiled in)
    noisy = 4'b0001;
    tick(7);
    chk("hold_qual_press", press_pulse, 4'b0001);
    pc = press_cnt[0];
    tick(10);
    chk("hold_plus10_press", press_pulse, RPT ? 4'b0001 : 4'b0000);
    tick(20);
    chk_int("hold_30_press_count", press_cnt[0] - pc, RPT ? 8 : 1);

    // reset while held: fresh qualification afterwards
    rst = 1'b1;
    tick(1);
    chk("midrst_clean", clean, 4'b0000);
    chk("midrst_press", press_pulse, 4'b0000);
    rst = 1'b0;
    tick(6);
    chk("midrst_edge6_clean", clean, 4'b0000);
    tick(1);
    chk("midrst_requal_press", press_pulse, 4'b0001);
    chk("midrst_requal_clean", clean, 4'b0001);
    noisy = 4'b0000;
    tick(10);
    chk("final_clean", clean, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
